// File: rtl/alu_pkg.sv
// Shared definitions for the alu_pipe slice: ctrl bit positions and FSM states.
package alu_pkg;

  // Bit positions inside the 6-bit ctrl word {zx,nx,zy,ny,f,no}
  localparam int ZX = 5;
  localparam int NX = 4;
  localparam int ZY = 3;
  localparam int NY = 2;
  localparam int F  = 1;
  localparam int NO = 0;

  // Sequencer states; SHIFT is only reachable when ALU_SHIFT_EN is defined
  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: operand zero/invert, AND or ADD, output invert.
// Carry and signed overflow are taken from the adder before the output invert.
module alu_core
  import alu_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  output logic [WIDTH-1:0] result,
  output logic             cy,
  output logic             ov
);

  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] pre;
  logic [WIDTH:0]   sum;

  // Operand conditioning, function select and result inversion
  always_comb begin
    a = ctrl[ZX] ? '0 : x;
    if (ctrl[NX]) a = ~a;
    b = ctrl[ZY] ? '0 : y;
    if (ctrl[NY]) b = ~b;
    sum = {1'b0, a} + {1'b0, b};
    if (ctrl[F]) begin
      pre = sum[WIDTH-1:0];
      cy  = sum[WIDTH];
      ov  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
    end else begin
      pre = a & b;
      cy  = 1'b0;
      ov  = 1'b0;
    end
    result = ctrl[NO] ? ~pre : pre;
  end

endmodule

// File: rtl/alu_pipe.sv
// Single-slot registered ALU with valid/ready handshake on both sides.
// Optional feature macro ALU_SHIFT_EN adds a bit-serial shifter (one bit per
// cycle, SHIFT state); without it sh_en/sh_dir/sh_amt are ignored.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [5:0]       ctrl,
  input  logic             sh_en,
  input  logic             sh_dir,
  input  logic [SHW-1:0]   sh_amt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out,
  output logic             zr,
  output logic             ng,
  output logic             cy,
  output logic             ov
);

  logic [WIDTH-1:0] alu_res;
  logic             alu_cy;
  logic             alu_ov;

  logic             accept;
  logic             deliver;

  // Value and carry/overflow to load into the result register this edge
  logic             wr_en;
  logic [WIDTH-1:0] wr_val;
  logic             wr_cy;
  logic             wr_ov;

  alu_core #(.WIDTH(WIDTH)) u_core (
    .x      (x),
    .y      (y),
    .ctrl   (ctrl),
    .result (alu_res),
    .cy     (alu_cy),
    .ov     (alu_ov)
  );

  assign accept  = in_valid && in_ready;
  assign deliver = out_valid && out_ready;

`ifdef ALU_SHIFT_EN

  state_t           state;
  logic [SHW-1:0]   cnt;
  logic [WIDTH-1:0] shreg;
  logic             shdir;
  logic [WIDTH-1:0] sh_next;
  logic             sh_bit;

  assign in_ready = (state == IDLE) && (!out_valid || out_ready);

  // One-bit shift step and the bit that falls off the end
  always_comb begin
    sh_next = shdir ? {1'b0, shreg[WIDTH-1:1]} : {shreg[WIDTH-2:0], 1'b0};
    sh_bit  = shdir ? shreg[0] : shreg[WIDTH-1];
  end

  // Result source: final shift step, zero-length shift, or ALU op at accept
  always_comb begin
    wr_en  = 1'b0;
    wr_val = alu_res;
    wr_cy  = alu_cy;
    wr_ov  = alu_ov;
    if (state == SHIFT) begin
      wr_en  = (cnt == SHW'(1));
      wr_val = sh_next;
      wr_cy  = sh_bit;
      wr_ov  = 1'b0;
    end else if (sh_en) begin
      wr_en  = accept && (sh_amt == '0);
      wr_val = x;
      wr_cy  = 1'b0;
      wr_ov  = 1'b0;
    end else begin
      wr_en  = accept;
    end
  end

  // Shift sequencer: load on accept, step until the count runs out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      shreg <= '0;
      shdir <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (accept && sh_en && (sh_amt != '0)) begin
            shreg <= x;
            shdir <= sh_dir;
            cnt   <= sh_amt;
            state <= SHIFT;
          end
        end
        SHIFT: begin
          shreg <= sh_next;
          cnt   <= cnt - SHW'(1);
          if (cnt == SHW'(1)) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`else

  logic unused_sh;
  assign unused_sh = ^{sh_en, sh_dir, sh_amt};

  assign in_ready = !out_valid || out_ready;

  // Every accepted command is an ALU op
  always_comb begin
    wr_en  = accept;
    wr_val = alu_res;
    wr_cy  = alu_cy;
    wr_ov  = alu_ov;
  end

`endif

  // Result slot: writes only happen when the slot is empty or draining, so
  // a stalled result is never disturbed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid <= 1'b0;
      out       <= '0;
      zr        <= 1'b0;
      ng        <= 1'b0;
      cy        <= 1'b0;
      ov        <= 1'b0;
    end else begin
      if (wr_en) begin
        out_valid <= 1'b1;
        out       <= wr_val;
        zr        <= (wr_val == '0);
        ng        <= wr_val[WIDTH-1];
        cy        <= wr_cy;
        ov        <= wr_ov;
      end else if (deliver) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe (WIDTH=16): directed literal cases plus
// randomized traffic checked every cycle against a behavioural model.
module tb_alu_pipe;

  localparam int     W    = 16;
  localparam int     SW   = 4;
  localparam longint MASK = (64'd1 << W) - 1;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  x = '0;
  logic [W-1:0]  y = '0;
  logic [5:0]    ctrl = '0;
  logic          sh_en = 1'b0;
  logic          sh_dir = 1'b0;
  logic [SW-1:0] sh_amt = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [W-1:0]  out;
  logic          zr, ng, cy, ov;

  int n_pass  = 0;
  int n_total = 0;

  alu_pipe #(.WIDTH(W), .SHW(SW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .x(x), .y(y), .ctrl(ctrl), .sh_en(sh_en), .sh_dir(sh_dir), .sh_amt(sh_amt),
    .out_valid(out_valid), .out_ready(out_ready), .out(out),
    .zr(zr), .ng(ng), .cy(cy), .ov(ov)
  );

  always #5 clk = ~clk;

  typedef struct {
    longint val;
    bit     zr, ng, cy, ov;
  } res_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  function automatic res_t mk(input longint v, input bit c, input bit o);
    res_t r;
    r.val = v & MASK;
    r.zr  = (r.val == 0);
    r.ng  = ((r.val >> (W - 1)) & 1) != 0;
    r.cy  = c;
    r.ov  = o;
    return r;
  endfunction

  // Arithmetic reference: signed overflow from true signed range
  function automatic res_t ref_alu(input longint xv, input longint yv, input logic [5:0] c);
    longint a, b, r, sa, sb, s;
    bit cyv, ovv;
    cyv = 0;
    ovv = 0;
    a = c[5] ? 0 : xv;
    if (c[4]) a = ~a & MASK;
    b = c[3] ? 0 : yv;
    if (c[2]) b = ~b & MASK;
    if (c[1]) begin
      r   = a + b;
      cyv = (r > MASK);
      sa  = (a > MASK / 2) ? a - (MASK + 1) : a;
      sb  = (b > MASK / 2) ? b - (MASK + 1) : b;
      s   = sa + sb;
      ovv = (s > MASK / 2) || (s < -(MASK / 2) - 1);
    end else begin
      r = a & b;
    end
    if (c[0]) r = ~r;
    return mk(r, cyv, ovv);
  endfunction

  function automatic res_t ref_shift(input longint xv, input bit dir, input int amt);
    longint r;
    bit c;
    if (!dir) begin
      r = xv << amt;
      c = ((xv >> (W - amt)) & 1) != 0;
    end else begin
      r = xv >> amt;
      c = ((xv >> (amt - 1)) & 1) != 0;
    end
    return mk(r, c, 1'b0);
  endfunction

  // Model of the visible result slot and any in-flight shift
  bit   m_valid = 0;
  bit   m_busy  = 0;
  int   m_left  = 0;
  res_t m_res;
  res_t m_pend;

  // Compare process: check outputs, then advance the model over the next edge
  always @(negedge clk) begin
    bit er, acc, del;
    if (rst) begin
      chk("rst_valid", out_valid, 0);
      chk("rst_out", out, 0);
      chk("rst_flags", {zr, ng, cy, ov}, 0);
      m_valid = 0;
      m_busy  = 0;
      m_left  = 0;
    end else begin
      er = !m_busy && (!m_valid || out_ready);
      chk("in_ready", in_ready, er);
      chk("out_valid", out_valid, m_valid);
      if (m_valid) begin
        chk("out", out, m_res.val);
        chk("zr", zr, m_res.zr);
        chk("ng", ng, m_res.ng);
        chk("cy", cy, m_res.cy);
        chk("ov", ov, m_res.ov);
      end
      acc = in_valid && er;
      del = m_valid && out_ready;
      if (del) m_valid = 0;
      if (m_busy) begin
        m_left--;
        if (m_left == 0) begin
          m_res   = m_pend;
          m_valid = 1;
          m_busy  = 0;
        end
      end else if (acc) begin
`ifdef ALU_SHIFT_EN
        if (sh_en && sh_amt != 0) begin
          m_pend = ref_shift(x, sh_dir, int'(sh_amt));
          m_busy = 1;
          m_left = int'(sh_amt);
        end else if (sh_en) begin
          m_res   = mk(x, 0, 0);
          m_valid = 1;
        end else begin
          m_res   = ref_alu(x, y, ctrl);
          m_valid = 1;
        end
`else
        m_res   = ref_alu(x, y, ctrl);
        m_valid = 1;
`endif
      end
    end
  end

  // Offer one command and return just after the edge that accepts it
  task automatic send(input logic [W-1:0] xv, input logic [W-1:0] yv, input logic [5:0] c,
                      input logic se, input logic sd, input logic [SW-1:0] sa);
    x = xv; y = yv; ctrl = c; sh_en = se; sh_dir = sd; sh_amt = sa;
    in_valid = 1'b1;
    out_ready = 1'b1;
    #1;
    for (int i = 0; i < 50 && !in_ready; i++) begin
      @(posedge clk);
      #1;
    end
    if (!in_ready) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic expect_now(input string nm, input logic [W-1:0] ev,
                            input bit ezr, input bit eng, input bit ecy, input bit eov);
    chk({nm, "_valid"}, out_valid, 1);
    chk({nm, "_out"}, out, ev);
    chk({nm, "_zr"}, zr, ezr);
    chk({nm, "_ng"}, ng, eng);
    chk({nm, "_cy"}, cy, ecy);
    chk({nm, "_ov"}, ov, eov);
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom % 6)
      0: return '0;
      1: return '1;
      2: return 16'h7FFF;
      3: return 16'h8000;
      4: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  initial begin
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", out_valid, 0);
    chk("reset_out", out, 0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Literal ALU cases
    send(16'h0005, 16'h0003, 6'b000010, 0, 0, 0);
    expect_now("add_5_3", 16'h0008, 0, 0, 0, 0);
    send(16'h7FFF, 16'h0001, 6'b000010, 0, 0, 0);
    expect_now("add_ovf", 16'h8000, 0, 1, 0, 1);
    send(16'hFFFF, 16'h0001, 6'b000010, 0, 0, 0);
    expect_now("add_carry", 16'h0000, 1, 0, 1, 0);
    send(16'h1234, 16'h5678, 6'b101010, 0, 0, 0);
    expect_now("const0", 16'h0000, 1, 0, 0, 0);
    send(16'h1234, 16'h5678, 6'b111111, 0, 0, 0);
    expect_now("const1", 16'h0001, 0, 0, 1, 0);
    send(16'h1234, 16'h5678, 6'b001100, 0, 0, 0);
    expect_now("pass_x", 16'h1234, 0, 0, 0, 0);

    // Back-pressure: result held, input blocked, then drain and accept together
    send(16'h0101, 16'h0010, 6'b000010, 0, 0, 0);
    out_ready = 1'b0;
    in_valid = 1'b1;
    x = 16'h0002; y = 16'h0003; ctrl = 6'b000010; sh_en = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1;
      chk("hold_ready", in_ready, 0);
      chk("hold_out", out, 16'h0111);
    end
    out_ready = 1'b1;
    #1;
    chk("hold_release_ready", in_ready, 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    expect_now("hold_next", 16'h0005, 0, 0, 0, 0);

`ifdef ALU_SHIFT_EN
    send(16'h2001, 16'h0000, 6'b000000, 1, 0, 3);
    chk("shl_wait0", out_valid, 0);
    repeat (2) begin
      @(posedge clk);
      #1;
      chk("shl_wait", out_valid, 0);
    end
    @(posedge clk);
    #1;
    expect_now("shl3", 16'h0008, 0, 0, 1, 0);
    send(16'hABCD, 16'h0000, 6'b000000, 1, 1, 0);
    expect_now("sh0", 16'hABCD, 0, 1, 0, 0);
    // Abort a long shift with reset on its second SHIFT cycle
    send(16'hFFFF, 16'h0000, 6'b000000, 1, 0, 5);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("abort_valid", out_valid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("abort_ready", in_ready, 1);
    repeat (6) @(posedge clk);
    #1;
    chk("abort_noresult", out_valid, 0);
`else
    send(16'h0005, 16'h0003, 6'b000010, 1, 0, 3);
    expect_now("sh_ignored", 16'h0008, 0, 0, 0, 0);
`endif

    // Reset with a pending undelivered result
    send(16'h8000, 16'h8000, 6'b000010, 0, 0, 0);
    expect_now("pre_rst", 16'h0000, 1, 0, 1, 1);
    out_ready = 1'b0;
    rst = 1'b1;
    #1;
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_flags", {zr, ng, cy, ov}, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("post_rst_ready", in_ready, 1);

    // Randomized traffic with random back-pressure
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom % 3) != 0;
      x         = pick();
      y         = pick();
      ctrl      = 6'($urandom);
      sh_en     = ($urandom % 3) == 0;
      sh_dir    = 1'($urandom);
      sh_amt    = SW'($urandom);
      out_ready = ($urandom % 4) != 0;
      @(posedge clk);
      #1;
    end

    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
